sw_input_conditioner: RTL



---
 rtl/leglite_io_pkg.sv | 19 +
 rtl/sw_input_conditioner_cell.sv | 96 +++++++++
 rtl/sw_input_conditioner.sv | 57 +++++
 3 files changed

// File: rtl/leglite_io_pkg.sv
// Shared IO constants for the leglite memory/IO slice: switch port address,
// switch count and the default debounce length, plus the per-channel phase type.
package leglite_io_pkg;

    localparam int          SW_DB_CYCLES_DEFAULT = 1000;
    localparam logic [15:0] SW_ADDR              = 16'hfff0;
    localparam int          NUM_SW               = 2;

    typedef enum logic {
        SW_IDLE    = 1'b0,
        SW_QUALIFY = 1'b1
    } sw_phase_e;

    // A channel is qualifying whenever the synchronised pin disagrees with the accepted level.
    function automatic sw_phase_e sw_phase(input logic s2, input logic stable);
        return (s2 != stable) ? SW_QUALIFY : SW_IDLE;
    endfunction

endpackage

// File: rtl/sw_input_conditioner_cell.sv
// One switch channel: two-flop synchroniser, stability counter and accepted level.
// Edge pulse outputs exist only when SW_EDGE_EN is defined.
module sw_debounce_cell
    import leglite_io_pkg::*;
#(
    parameter int DB_CYCLES = SW_DB_CYCLES_DEFAULT,
    parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
`ifdef SW_EDGE_EN
    output logic rise,
    output logic fall,
`endif
    output logic level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             s1_r;
    logic             s2_r;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;
    sw_phase_e        phase_s;
    logic             accept_s;

    // Qualification status derived from the synchronised pin and accepted level.
    always_comb begin
        phase_s  = sw_phase(s2_r, stable_r);
        accept_s = 1'b0;
        if ((phase_s == SW_QUALIFY) && (cnt_r == CNT_LAST)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= raw;
            s2_r <= s1_r;
        end
    end

    // Stability counter; any return to the accepted level discards progress.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r    <= '0;
            stable_r <= 1'b0;
        end else begin
            case (phase_s)
                SW_IDLE: begin
                    cnt_r <= '0;
                end
                SW_QUALIFY: begin
                    if (accept_s) begin
                        stable_r <= s2_r;
                        cnt_r    <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign level = stable_r;

`ifdef SW_EDGE_EN
    logic rise_r;
    logic fall_r;

    // One-cycle pulses issued on the edge that flips the accepted level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            rise_r <= accept_s & s2_r;
            fall_r <= accept_s & ~s2_r;
        end
    end

    assign rise = rise_r;
    assign fall = fall_r;
`endif

endmodule

// File: rtl/sw_input_conditioner.sv
// Slide-switch conditioner feeding the 0xfff0 input port: two independent debounce channels.
// Define SW_EDGE_EN to add the per-switch rise/fall pulse outputs.
module sw_input_conditioner
    import leglite_io_pkg::*;
#(
    parameter int DB_CYCLES = SW_DB_CYCLES_DEFAULT,
    parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw_sw0,
    input  logic raw_sw1,
`ifdef SW_EDGE_EN
    output logic sw0_rise,
    output logic sw0_fall,
    output logic sw1_rise,
    output logic sw1_fall,
`endif
    output logic io_sw0,
    output logic io_sw1
);

    logic [NUM_SW-1:0] raw_s;
    logic [NUM_SW-1:0] level_s;
`ifdef SW_EDGE_EN
    logic [NUM_SW-1:0] rise_s;
    logic [NUM_SW-1:0] fall_s;
`endif

    assign raw_s = {raw_sw1, raw_sw0};

    for (genvar g = 0; g < NUM_SW; g++) begin : g_cell
        sw_debounce_cell #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_cell (
            .clock   (clock),
            .reset_n (reset_n),
            .raw     (raw_s[g]),
`ifdef SW_EDGE_EN
            .rise    (rise_s[g]),
            .fall    (fall_s[g]),
`endif
            .level   (level_s[g])
        );
    end

    assign io_sw0 = level_s[0];
    assign io_sw1 = level_s[1];
`ifdef SW_EDGE_EN
    assign sw0_rise = rise_s[0];
    assign sw0_fall = fall_s[0];
    assign sw1_rise = rise_s[1];
    assign sw1_fall = fall_s[1];
`endif

endmodule
